// File: rtl/leaf_out_merge_pkg.sv
// rtl/leaf_out_merge_pkg.sv - shared constants and helpers for the leaf output merge
`define LEAF_XFER(vld, ack) ((vld) && (ack))
`define LEAF_SLICE(bus, i, w) bus[(i)*(w) +: (w)]

package leaf_out_merge_pkg;

  localparam int DEF_PAYLOAD_BITS  = 32;
  localparam int DEF_NUM_PORT_BITS = 4;
  localparam int DEF_CREDIT_BITS   = 8;

  // Never returns 0 so that a single-channel build still gets a 1-bit index.
  function automatic int leaf_clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/leaf_sync_fifo.sv
// rtl/leaf_sync_fifo.sv - first-word-fall-through synchronous FIFO with occupancy count
module leaf_sync_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_BITS = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      din_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      dout_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_BITS:0]   count_o
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]   count_q, count_d;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == (DEPTH_BITS + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + DEPTH_BITS'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + DEPTH_BITS'(1);
    if (do_push && !do_pop)      count_d = count_q + (DEPTH_BITS + 1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (DEPTH_BITS + 1)'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count alone decide what is visible.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/leaf_out_merge.sv
// rtl/leaf_out_merge.sv - per-channel FIFOs merged round-robin into one credit-gated tagged stream
module leaf_out_merge
  import leaf_out_merge_pkg::*;
#(
  parameter int NUM_CH          = 3,
  parameter int PAYLOAD_BITS    = DEF_PAYLOAD_BITS,
  parameter int NUM_PORT_BITS   = DEF_NUM_PORT_BITS,
  parameter int FIFO_DEPTH_BITS = 2,
  parameter int CREDIT_BITS     = DEF_CREDIT_BITS,
  parameter int INIT_CREDIT     = 64
) (
  input  logic                           clk_user,
  input  logic                           reset,
  input  logic [NUM_CH*PAYLOAD_BITS-1:0] din_user,
  input  logic [NUM_CH-1:0]              vld_user,
  output logic [NUM_CH-1:0]              ack_user,
  output logic [PAYLOAD_BITS-1:0]        dout,
  output logic [NUM_PORT_BITS-1:0]       dout_port,
  output logic                           dout_vld,
  input  logic                           dout_ack,
  input  logic                           credit_upd_vld,
  input  logic [NUM_PORT_BITS-1:0]       credit_upd_port,
  input  logic [CREDIT_BITS-1:0]         credit_upd_val,
  output logic [NUM_CH-1:0]              credit_zero
);

  localparam int IDX_BITS = leaf_clog2(NUM_CH);
  localparam logic [CREDIT_BITS-1:0] CREDIT_MAX = '1;
  localparam logic [CREDIT_BITS-1:0] CREDIT_RST = CREDIT_BITS'(INIT_CREDIT);

  logic [PAYLOAD_BITS-1:0]    fifo_dout  [NUM_CH];
  logic [FIFO_DEPTH_BITS:0]   fifo_count [NUM_CH];
  logic [NUM_CH-1:0]          fifo_full, fifo_empty, fifo_push, fifo_pop, eligible;
  logic [CREDIT_BITS-1:0]     credit_q [NUM_CH];
  logic [CREDIT_BITS-1:0]     credit_d [NUM_CH];
  logic [IDX_BITS-1:0]        last_grant_q, last_grant_d, grant_idx, cand;
  logic                       grant_any, load;
  logic [PAYLOAD_BITS-1:0]    dout_q, dout_d;
  logic [NUM_PORT_BITS-1:0]   dout_port_q, dout_port_d;
  logic                       dout_vld_q, dout_vld_d;

  assign ack_user  = ~fifo_full;
  assign dout      = dout_q;
  assign dout_port = dout_port_q;
  assign dout_vld  = dout_vld_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic                 upd_hit;
    logic [CREDIT_BITS:0] credit_sum;
    logic                 fifo_count_unused;

    assign fifo_push[i] = `LEAF_XFER(vld_user[i], ack_user[i]);
    assign fifo_pop[i]  = load && (grant_idx == IDX_BITS'(i));

    leaf_sync_fifo #(
      .WIDTH      (PAYLOAD_BITS),
      .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
      .clk_i   (clk_user),
      .rst_i   (reset),
      .push_i  (fifo_push[i]),
      .din_i   (`LEAF_SLICE(din_user, i, PAYLOAD_BITS)),
      .pop_i   (fifo_pop[i]),
      .dout_o  (fifo_dout[i]),
      .full_o  (fifo_full[i]),
      .empty_o (fifo_empty[i]),
      .count_o (fifo_count[i])
    );

    assign fifo_count_unused = ^fifo_count[i];
    assign eligible[i]       = !fifo_empty[i] && (credit_q[i] != '0);
    assign credit_zero[i]    = (credit_q[i] == '0);

    // One extra bit catches overflow; a grant only happens at credit >= 1, so no underflow.
    assign upd_hit    = credit_upd_vld && (credit_upd_port == NUM_PORT_BITS'(i));
    assign credit_sum = {1'b0, credit_q[i]}
                      + (upd_hit ? {1'b0, credit_upd_val} : '0)
                      - (CREDIT_BITS + 1)'(fifo_pop[i]);
    assign credit_d[i] = credit_sum[CREDIT_BITS] ? CREDIT_MAX : credit_sum[CREDIT_BITS-1:0];
  end

  // Walk downward so the last hit is the first eligible channel after last_grant.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = IDX_BITS'((int'(last_grant_q) + k) % NUM_CH);
      if (eligible[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    load         = grant_any && (!dout_vld_q || dout_ack);
    dout_d       = dout_q;
    dout_port_d  = dout_port_q;
    dout_vld_d   = dout_vld_q;
    last_grant_d = last_grant_q;
    if (load) begin
      dout_d       = fifo_dout[grant_idx];
      dout_port_d  = NUM_PORT_BITS'(grant_idx);
      dout_vld_d   = 1'b1;
      last_grant_d = grant_idx;
    end else if (dout_ack) begin
      dout_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_user or posedge reset) begin
    if (reset) begin
      dout_q       <= '0;
      dout_port_q  <= '0;
      dout_vld_q   <= 1'b0;
      last_grant_q <= IDX_BITS'(NUM_CH - 1);
      for (int i = 0; i < NUM_CH; i++) credit_q[i] <= CREDIT_RST;
    end else begin
      dout_q       <= dout_d;
      dout_port_q  <= dout_port_d;
      dout_vld_q   <= dout_vld_d;
      last_grant_q <= last_grant_d;
      for (int i = 0; i < NUM_CH; i++) credit_q[i] <= credit_d[i];
    end
  end

endmodule

// File: tb/tb_leaf_out_merge.sv
// tb/tb_leaf_out_merge.sv - directed self-checking bench for leaf_out_merge
module tb_leaf_out_merge;

  logic clk_user = 1'b0;
  logic reset;
  always #5 clk_user = ~clk_user;

  logic [95:0] din_a, din_b;
  logic [2:0]  vld_a, vld_b, ack_a, ack_b, cz_a, cz_b;
  logic [31:0] dout_a, dout_b;
  logic [3:0]  port_a, port_b, cu_port_a, cu_port_b;
  logic        dvld_a, dvld_b, dack_a, dack_b, cu_vld_a, cu_vld_b;
  logic [7:0]  cu_val_a, cu_val_b;

  int checks = 0;
  int errors = 0;
  int got;

  int ex_vld  [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
  int ex_port [8] = '{0, 0, 2, 0, 2, 2, 2, 0};
  int ex_k    [8] = '{0, 0, 0, 1, 1, 2, 3, 0};

  leaf_out_merge #(
    .NUM_CH(3), .PAYLOAD_BITS(32), .NUM_PORT_BITS(4),
    .FIFO_DEPTH_BITS(2), .CREDIT_BITS(8), .INIT_CREDIT(64)
  ) dut_a (
    .clk_user(clk_user), .reset(reset), .din_user(din_a), .vld_user(vld_a),
    .ack_user(ack_a), .dout(dout_a), .dout_port(port_a), .dout_vld(dvld_a),
    .dout_ack(dack_a), .credit_upd_vld(cu_vld_a), .credit_upd_port(cu_port_a),
    .credit_upd_val(cu_val_a), .credit_zero(cz_a)
  );

  leaf_out_merge #(
    .NUM_CH(3), .PAYLOAD_BITS(32), .NUM_PORT_BITS(4),
    .FIFO_DEPTH_BITS(2), .CREDIT_BITS(8), .INIT_CREDIT(2)
  ) dut_b (
    .clk_user(clk_user), .reset(reset), .din_user(din_b), .vld_user(vld_b),
    .ack_user(ack_b), .dout(dout_b), .dout_port(port_b), .dout_vld(dvld_b),
    .dout_ack(dack_b), .credit_upd_vld(cu_vld_b), .credit_upd_port(cu_port_b),
    .credit_upd_val(cu_val_b), .credit_zero(cz_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_user);
    #1;
  endtask

  task automatic do_reset();
    #3 reset = 1'b1;
    #1 reset = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] rr_word(input int ch, input int w);
    return 32'((ch + 1) << 28) | 32'(w);
  endfunction

  function automatic logic [31:0] bp_word(input int k);
    return 32'hB0B0_0000 | 32'(k);
  endfunction

  function automatic logic [31:0] ex_word(input int ch, input int k);
    return ((ch == 0) ? 32'hA000_0000 : 32'hC000_0000) | 32'(k);
  endfunction

  function automatic logic [31:0] st_word(input int ch, input int k);
    return 32'hD000_0000 | 32'(ch << 20) | 32'(k);
  endfunction

  task automatic wait_ack_a(input int ch);
    int n;
    n = 0;
    while (!ack_a[ch[1:0]] && n < 20) begin
      tick();
      n++;
    end
    chk("wait_ack", 32'(ack_a[ch[1:0]]), 32'd1);
  endtask

  // Streams words first..last into dut_b channel ch with dout_ack held high,
  // applying one credit update on the first edge; returns words seen on dout.
  task automatic stream_b(input int ch, input int first, input int last, input int cycles,
                          input logic [3:0] cport, input logic [7:0] cval, output int n_out);
    int  pi;
    logic pend;
    pi    = first;
    n_out = 0;
    for (int c = 0; c < cycles; c++) begin
      vld_b = '0;
      if (pi <= last) vld_b[ch[1:0]] = 1'b1;
      din_b = '0;
      din_b[ch*32 +: 32] = st_word(ch, pi);
      cu_vld_b  = (c == 0);
      cu_port_b = cport;
      cu_val_b  = cval;
      if (dvld_b) begin
        chk("stream_port", 32'(port_b), 32'(ch));
        chk("stream_data", dout_b, st_word(ch, n_out));
        n_out++;
      end
      pend = vld_b[ch[1:0]] && ack_b[ch[1:0]];
      tick();
      if (pend) pi++;
    end
    vld_b    = '0;
    cu_vld_b = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    din_a = '0; vld_a = '0; dack_a = 1'b0; cu_vld_a = 1'b0; cu_port_a = '0; cu_val_a = '0;
    din_b = '0; vld_b = '0; dack_b = 1'b1; cu_vld_b = 1'b0; cu_port_b = '0; cu_val_b = '0;
    #1 reset = 1'b1;
    #2;
    chk("rst_ack", 32'(ack_a), 32'h7);
    chk("rst_dvld", 32'(dvld_a), 32'h0);
    chk("rst_dout", dout_a, 32'h0);
    chk("rst_port", 32'(port_a), 32'h0);
    chk("rst_cz_a", 32'(cz_a), 32'h0);
    chk("rst_cz_b", 32'(cz_b), 32'h0);
    tick();
    reset = 1'b0;
    tick();

    // Reset mid-operation: output register loaded, ch0 FIFO half full
    for (int k = 0; k < 3; k++) begin
      vld_a = 3'b001;
      din_a = {64'h0, bp_word(16 + k)};
      tick();
    end
    vld_a = '0;
    chk("mid_pre_dvld", 32'(dvld_a), 32'h1);
    chk("mid_pre_dout", dout_a, bp_word(16));
    #3 reset = 1'b1;
    #1;
    chk("mid_dvld", 32'(dvld_a), 32'h0);
    chk("mid_ack", 32'(ack_a), 32'h7);
    chk("mid_cz", 32'(cz_a), 32'h0);
    chk("mid_dout", dout_a, 32'h0);
    #1 reset = 1'b0;
    dack_a = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("mid_no_old", 32'(dvld_a), 32'h0);
    end

    // Single word on ch1: two-cycle latency
    dack_a = 1'b0;
    vld_a  = 3'b010;
    din_a  = {32'h0, 32'hA5A5_A5A5, 32'h0};
    tick();
    vld_a = '0;
    chk("lat_e1_dvld", 32'(dvld_a), 32'h0);
    tick();
    chk("lat_e2_dvld", 32'(dvld_a), 32'h1);
    chk("lat_e2_dout", dout_a, 32'hA5A5_A5A5);
    chk("lat_e2_port", 32'(port_a), 32'h1);
    dack_a = 1'b1;
    tick();
    chk("lat_e3_dvld", 32'(dvld_a), 32'h0);

    // Round-robin with all channels loaded in parallel
    do_reset();
    dack_a = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      if (e <= 4) begin
        chk("rr_ack", 32'(ack_a), 32'h7);
        vld_a = 3'b111;
        din_a = {rr_word(2, e - 1), rr_word(1, e - 1), rr_word(0, e - 1)};
      end else begin
        vld_a = '0;
      end
      tick();
      if (e >= 2 && e <= 13) begin
        chk("rr_dvld", 32'(dvld_a), 32'h1);
        chk("rr_port", 32'(port_a), 32'((e - 2) % 3));
        chk("rr_data", dout_a, rr_word((e - 2) % 3, (e - 2) / 3));
      end else if (e == 14) begin
        chk("rr_end_dvld", 32'(dvld_a), 32'h0);
      end
    end

    // Backpressure: 5 accepted, 6th held until dout_ack releases
    do_reset();
    dack_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      vld_a = 3'b001;
      din_a = {64'h0, bp_word(k)};
      wait_ack_a(0);
      tick();
    end
    din_a = {64'h0, bp_word(5)};
    chk("bp_ack_drop", 32'(ack_a), 32'h6);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_hold_dvld", 32'(dvld_a), 32'h1);
      chk("bp_hold_dout", dout_a, bp_word(0));
      chk("bp_hold_ack", 32'(ack_a), 32'h6);
    end
    dack_a = 1'b1;
    got = 0;
    for (int c = 0; c < 30 && got < 6; c++) begin
      logic pend;
      if (dvld_a) begin
        chk("bp_drain", dout_a, bp_word(got));
        got++;
      end
      pend = vld_a[0] && ack_a[0];
      tick();
      if (pend) vld_a = '0;
    end
    chk("bp_count", 32'(got), 32'd6);

    // Credit exhaustion on dut_b (INIT_CREDIT 2); ch2 topped up on the first edge
    do_reset();
    dack_b = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      if (e <= 4) begin
        vld_b = 3'b101;
        din_b = {ex_word(2, e - 1), 32'h0, ex_word(0, e - 1)};
      end else begin
        vld_b = '0;
      end
      cu_vld_b  = (e == 1);
      cu_port_b = 4'd2;
      cu_val_b  = 8'd10;
      tick();
      cu_vld_b = 1'b0;
      chk("ex_dvld", 32'(dvld_b), 32'(ex_vld[e-1]));
      if (ex_vld[e-1] != 0) begin
        chk("ex_port", 32'(port_b), 32'(ex_port[e-1]));
        chk("ex_data", dout_b, ex_word(ex_port[e-1], ex_k[e-1]));
      end
      if (e == 4) chk("ex_cz_stall", 32'(cz_b), 32'h1);
    end
    chk("ex_cz_after", 32'(cz_b), 32'h1);
    cu_vld_b = 1'b1; cu_port_b = 4'd0; cu_val_b = 8'd3;
    tick();
    cu_vld_b = 1'b0;
    chk("ex_upd_cz", 32'(cz_b), 32'h0);
    chk("ex_upd_dvld", 32'(dvld_b), 32'h0);
    tick();
    chk("ex_rel0_port", 32'(port_b), 32'h0);
    chk("ex_rel0_data", dout_b, ex_word(0, 2));
    tick();
    chk("ex_rel1_data", dout_b, ex_word(0, 3));
    tick();
    chk("ex_rel_end", 32'(dvld_b), 32'h0);
    vld_b = 3'b001;
    din_b = {64'h0, ex_word(0, 4)};
    tick();
    din_b = {64'h0, ex_word(0, 5)};
    tick();
    vld_b = '0;
    chk("ex_last_data", dout_b, ex_word(0, 4));
    chk("ex_last_cz", 32'(cz_b), 32'h1);
    tick();
    chk("ex_last_stall", 32'(dvld_b), 32'h0);

    // Grant and credit update on the same channel in the same cycle: 5 + 10 - 1
    do_reset();
    vld_b = 3'b010;
    din_b = {32'h0, st_word(1, 0), 32'h0};
    cu_vld_b = 1'b1; cu_port_b = 4'd1; cu_val_b = 8'd3;
    tick();
    vld_b = '0;
    cu_vld_b = 1'b0;
    stream_b(1, 1, 20, 40, 4'd1, 8'd10, got);
    chk("sim_count", 32'(got), 32'd15);
    chk("sim_cz", 32'(cz_b), 32'h2);

    // Saturation: 200 + 255 clamps at 255
    do_reset();
    cu_vld_b = 1'b1; cu_port_b = 4'd0; cu_val_b = 8'd198;
    tick();
    cu_vld_b = 1'b0;
    stream_b(0, 0, 299, 320, 4'd0, 8'd255, got);
    chk("sat_count", 32'(got), 32'd255);
    chk("sat_cz", 32'(cz_b), 32'h1);

    // Out-of-range port leaves all credits alone
    do_reset();
    stream_b(1, 0, 5, 15, 4'd7, 8'd5, got);
    chk("port7_count", 32'(got), 32'd2);
    chk("port7_cz", 32'(cz_b), 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/leaf_out_merge.md
Name: leaf_out_merge

Overview:
- Parametrised user-to-interface output stage for a leaf.
- Accepts NUM_CH independent operator output streams using the ap_vld/ap_ack handshake, and buffers each one in its own FIFO.
- Merges the FIFOs into one tagged stream toward leaf_interface, using round-robin arbitration.
- Each channel has a credit counter that tracks downstream freespace. A channel with zero credit is stalled without blocking the other channels.

Parameters:
- NUM_CH, 3, number of user output channels (1..16).
- PAYLOAD_BITS, 32, data width per channel.
- NUM_PORT_BITS, 4, width of the channel tag on the output; must satisfy 2**NUM_PORT_BITS >= NUM_CH.
- FIFO_DEPTH_BITS, 2, log2 of per-channel FIFO depth (depth 4 by default).
- CREDIT_BITS, 8, width of each credit counter.
- INIT_CREDIT, 64, credit value loaded at reset; must be <= 2**CREDIT_BITS-1.

Ports:
- clk_user  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- din_user  in  NUM_CH*PAYLOAD_BITS  channel data; channel i occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
- vld_user  in  NUM_CH  per-channel valid.
- ack_user  out  NUM_CH  per-channel accept.
- dout  out  PAYLOAD_BITS  merged data.
- dout_port  out  NUM_PORT_BITS  source channel index of dout.
- dout_vld  out  1  merged valid.
- dout_ack  in  1  interface accept.
- credit_upd_vld  in  1  credit return strobe.
- credit_upd_port  in  NUM_PORT_BITS  channel receiving credit.
- credit_upd_val  in  CREDIT_BITS  credit amount to add.
- credit_zero  out  NUM_CH  status; bit i = (credit[i]==0).

Behaviour:
- Handshake rule (both sides): a transfer occurs in any cycle where vld and ack are both high. A source must hold its vld and data until the transfer occurs.
- ack_user[i] = !full[i]:
  - derived only from registered FIFO state, with no combinational path from vld_user;
  - data is written on vld_user[i] && ack_user[i].
- FIFO behaviour:
  - write to a full FIFO is impossible because ack is low;
  - simultaneous read and write on a full FIFO is not permitted, because ack is low;
  - simultaneous read and write on a non-full, non-empty FIFO keeps the count unchanged;
  - pointers wrap modulo 2**FIFO_DEPTH_BITS.
- Channel i is eligible when its FIFO is non-empty and credit[i] > 0.
- Output register:
  - dout, dout_port and dout_vld are registered;
  - the register loads when (!dout_vld || dout_ack) and at least one channel is eligible;
  - if the register loads while a transfer occurs, a new word appears in the next cycle, giving full throughput of 1 word/cycle;
  - if no channel is eligible, dout_vld falls after the transfer.
- Latency: a word written at edge N can appear on dout after edge N+1 at the earliest, i.e. 2 cycles from vld_user to dout_vld.
- Arbitration:
  - the last_grant register resets to NUM_CH-1;
  - the next grant is the first eligible channel searching from last_grant+1 upward, mod NUM_CH;
  - on each grant, last_grant is updated, the granted FIFO is popped and its credit is decremented.
- Credit update:
  - on credit_upd_vld, credit[credit_upd_port] += credit_upd_val;
  - a grant in the same cycle on the same channel yields credit + val - 1;
  - the result saturates at 2**CREDIT_BITS-1;
  - credit_upd_port >= NUM_CH is ignored;
  - credit can never go below zero, because a channel with zero credit is ineligible.
- Reset state:
  - ack_user = all ones, dout_vld = 0, dout = 0, dout_port = 0;
  - credit_zero = 0 if INIT_CREDIT > 0, otherwise all ones;
  - FIFOs are empty and credits equal INIT_CREDIT;
  - reset asserted mid-transfer discards buffered words and the output register word.
- dout_vld must not drop without dout_ack, and dout and dout_port must be stable while dout_vld && !dout_ack.

Decomposition:
- A shared package or header holds:
  - the handshake-transfer macro;
  - the clog2 helper;
  - the packed-slice helper for channel i;
  - the default PAYLOAD_BITS, NUM_PORT_BITS and CREDIT_BITS constants that are common with leaf_interface.
- One natural sub-module, leaf_sync_fifo:
  - parameters WIDTH and DEPTH_BITS;
  - provides full, empty, push, pop and count;
  - output is first-word-fall-through;
  - instantiated NUM_CH times via generate.
- The arbiter, credits and output register stay in the top module.

Test Plan:
- Reset values: assert reset asynchronously mid-cycle -> ack_user=3'b111, dout_vld=0, and all credits read 64 via credit_zero=0 on the same edge. After deassert, a single word 0xA5A5A5A5 on ch1 -> dout=0xA5A5A5A5, dout_port=1, with dout_vld 2 cycles after vld_user.
- Round-robin: all 3 channels hold 4 words each and dout_ack is tied 1 -> dout_port sequence 0,1,2,0,1,2,... at 1 word/cycle, and data order within each channel is preserved.
- Backpressure: dout_ack=0 and ch0 streams 6 words -> ack_user[0] drops after 5 accepted (4 in FIFO + 1 in output register). dout stays stable; releasing dout_ack drains all 6 in order.
- Credit exhaustion:
  - with INIT_CREDIT=2 and ch0 given 4 words, ch2 given 4 words -> after ch0 sends 2 words it stalls with credit_zero[0]=1, while ch2 continues;
  - credit_upd (port 0, val 3) then releases the 2 stalled ch0 words and leaves credit 1.
- Simultaneous credit and grant: the cycle ch1 is granted with credit 5 also carries credit_upd (port 1, val 10) -> credit becomes 14. Update with val 255 at credit 200 -> saturates at 255. Update with port 7 -> no credit changes.
- Reset mid-operation: FIFOs half full and dout_vld=1, then pulse reset -> dout_vld=0 immediately, the old words are never emitted, and credits return to INIT_CREDIT.
